// File: rtl/sm_pkg.sv
// Shared types and default sizing for the softermax probability reader.
package sm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } sm_state_e;

  localparam int SM_ROW_WIDTH  = 8;
  localparam int SM_LARGE_SIZE = 32;
  localparam int SM_OUT_SIZE   = 8;

endpackage

// File: rtl/sm_prob_fifo.sv
// Two-entry output FIFO built as head/tail registers so the head drives the
// block outputs directly from flops.
module sm_prob_fifo
  import sm_pkg::*;
#(
  parameter int DW = SM_OUT_SIZE,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic [IW-1:0] i_idx,
  input  logic          i_last,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic [IW-1:0] o_idx,
  output logic          o_last,
  output logic [1:0]    o_count
);

  logic          r_head_v, r_tail_v;
  logic [DW-1:0] r_head_d, r_tail_d;
  logic [IW-1:0] r_head_i, r_tail_i;
  logic          r_head_l, r_tail_l;
  logic          w_pop;

  assign w_pop = r_head_v & i_ready;

  // Head/tail update; the reader's credit rule guarantees no push into a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head_v <= 1'b0;
      r_head_d <= '0;
      r_head_i <= '0;
      r_head_l <= 1'b0;
      r_tail_v <= 1'b0;
      r_tail_d <= '0;
      r_tail_i <= '0;
      r_tail_l <= 1'b0;
    end else if (i_push) begin
      if (!r_head_v || (w_pop && !r_tail_v)) begin
        r_head_v <= 1'b1;
        r_head_d <= i_data;
        r_head_i <= i_idx;
        r_head_l <= i_last;
      end else if (w_pop) begin
        r_head_d <= r_tail_d;
        r_head_i <= r_tail_i;
        r_head_l <= r_tail_l;
        r_tail_d <= i_data;
        r_tail_i <= i_idx;
        r_tail_l <= i_last;
      end else begin
        r_tail_v <= 1'b1;
        r_tail_d <= i_data;
        r_tail_i <= i_idx;
        r_tail_l <= i_last;
      end
    end else if (w_pop) begin
      r_head_v <= r_tail_v;
      r_head_d <= r_tail_d;
      r_head_i <= r_tail_i;
      r_head_l <= r_tail_l;
      r_tail_v <= 1'b0;
    end
  end

  assign o_valid = r_head_v;
  assign o_data  = r_head_d;
  assign o_idx   = r_head_i;
  assign o_last  = r_head_l;
  assign o_count = {1'b0, r_head_v} + {1'b0, r_tail_v};

endmodule

// File: rtl/sm_prob_reader.sv
// Reads one softermax probability row, quantizes it and streams it out with
// valid/ready. Define SM_PROB_ROUND_EN for round-half-up instead of truncation.
module sm_prob_reader
  import sm_pkg::*;
#(
  parameter int ROW_WIDTH  = SM_ROW_WIDTH,
  parameter int LARGE_SIZE = SM_LARGE_SIZE,
  parameter int OUT_SIZE   = SM_OUT_SIZE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         norm_valid,
  output logic [$clog2(ROW_WIDTH)-1:0] read_addr,
  input  logic [LARGE_SIZE:0]          prob_buffer_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_SIZE-1:0]          out_data,
  output logic [$clog2(ROW_WIDTH)-1:0] out_idx,
  output logic                         out_last,
  output logic                         busy,
  output logic                         err_overrun
);

  localparam int AW    = $clog2(ROW_WIDTH);
  localparam int SHIFT = LARGE_SIZE - OUT_SIZE;
  localparam logic [AW-1:0]         LAST_ADDR = AW'(ROW_WIDTH - 1);
  localparam logic [LARGE_SIZE+1:0] SAT_LIM   = (LARGE_SIZE+2)'(1'b1) << OUT_SIZE;
`ifdef SM_PROB_ROUND_EN
  localparam logic [LARGE_SIZE+1:0] RND = (LARGE_SIZE+2)'(1'b1) << (SHIFT - 1);
`else
  localparam logic [LARGE_SIZE+1:0] RND = '0;
`endif

  function automatic logic [OUT_SIZE-1:0] quantize(input logic [LARGE_SIZE:0] p);
    logic [LARGE_SIZE+1:0] w_sum;
    w_sum = ({1'b0, p} + RND) >> SHIFT;
    if (w_sum >= SAT_LIM) begin
      quantize = '1;
    end else begin
      quantize = w_sum[OUT_SIZE-1:0];
    end
  endfunction

  sm_state_e     r_state, w_state_nxt;
  logic [AW-1:0] r_read_addr, r_rd_idx;
  logic          r_rd_pend, r_busy, r_err;
  logic          w_issue, w_pop;
  logic          w_fifo_valid, w_fifo_last;
  logic [1:0]    w_fifo_count;

  assign w_pop   = w_fifo_valid & out_ready;
  // The slot freed by this cycle's pop counts as a credit, keeping the stream bubble-free.
  assign w_issue = (r_state == READ) &&
                   (({1'b0, w_fifo_count} + {2'b00, r_rd_pend}) < (3'd2 + {2'b00, w_pop}));

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (norm_valid) w_state_nxt = READ;
        else            w_state_nxt = IDLE;
      end
      READ: begin
        if (w_issue && (r_read_addr == LAST_ADDR)) w_state_nxt = DRAIN;
        else                                       w_state_nxt = READ;
      end
      DRAIN: begin
        if (w_pop && w_fifo_last) w_state_nxt = IDLE;
        else                      w_state_nxt = DRAIN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, read address, in-flight read tracking and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_read_addr <= '0;
      r_rd_pend   <= 1'b0;
      r_rd_idx    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_rd_pend <= w_issue;
      if ((r_state == IDLE) && norm_valid) begin
        r_read_addr <= '0;
      end else if (w_issue) begin
        r_read_addr <= r_read_addr + 1'b1;
      end
      if (w_issue) begin
        r_rd_idx <= r_read_addr;
      end
      if (norm_valid && (r_state != IDLE)) begin
        r_err <= 1'b1;
      end
    end
  end

  sm_prob_fifo #(
    .DW (OUT_SIZE),
    .IW (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_rd_pend),
    .i_data  (quantize(prob_buffer_out)),
    .i_idx   (r_rd_idx),
    .i_last  (r_rd_idx == LAST_ADDR),
    .i_ready (out_ready),
    .o_valid (w_fifo_valid),
    .o_data  (out_data),
    .o_idx   (out_idx),
    .o_last  (w_fifo_last),
    .o_count (w_fifo_count)
  );

  assign out_valid   = w_fifo_valid;
  assign out_last    = w_fifo_last;
  assign read_addr   = r_read_addr;
  assign busy        = r_busy;
  assign err_overrun = r_err;

endmodule

// File: tb/tb_sm_prob_reader.sv
// Scoreboard bench for sm_prob_reader: expected rows are queued when norm_valid
// is driven and compared as elements are transferred.
module tb_sm_prob_reader;

  localparam int RW = 8;
  localparam int LS = 32;
  localparam int OS = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst, norm_valid, out_ready;
  logic [AW-1:0] read_addr, out_idx;
  logic [LS:0]   prob_buffer_out;
  logic          out_valid, out_last, busy, err_overrun;
  logic [OS-1:0] out_data;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] idx;
    logic       last;
  } exp_t;

  exp_t        sb[$];
  logic [LS:0] mem [RW];
  int n_err = 0;
  int n_checks = 0;
  int cyc = 0;
  int acc_total = 0;
  int acc_base = 0;
  int last_cyc = 0;
  int n0 = 0;
  int ready_mode = 0;
  bit credit_chk = 1'b0;

  sm_prob_reader dut (
    .clk             (clk),
    .rst             (rst),
    .norm_valid      (norm_valid),
    .read_addr       (read_addr),
    .prob_buffer_out (prob_buffer_out),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_idx         (out_idx),
    .out_last        (out_last),
    .busy            (busy),
    .err_overrun     (err_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) prob_buffer_out <= mem[read_addr];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_q(input logic [32:0] p);
    logic [33:0] v;
    v = {1'b0, p};
`ifdef SM_PROB_ROUND_EN
    v = v + 34'h0_0080_0000;
`endif
    v = v >> 24;
    if (v > 34'd255) return 8'hFF;
    else return v[7:0];
  endfunction

  task automatic chk_reset_vals();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_overrun, 0);
    check("rst_read_addr", read_addr, 0);
  endtask

  // Pulse norm_valid for one cycle; returns #1 into cycle N+1.
  task automatic fire();
    @(posedge clk); #1;
    norm_valid = 1'b1;
    n0 = cyc;
    acc_base = acc_total;
    for (int i = 0; i < RW; i++) sb.push_back({exp_q(mem[i]), 3'(i), (i == RW - 1)});
    @(posedge clk); #1;
    norm_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    check("idle_timeout", busy, 0);
    @(negedge clk);
    check("sb_empty", sb.size(), 0);
  endtask

  // out_ready driver: 0 = always high, 1 = 1,0,0,1 pattern, 2 = random.
  initial begin
    int k;
    k = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 1) out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      else if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
      k++;
    end
  end

  // Transfer monitor: scoreboard compare, stall stability and read-credit bound.
  initial begin
    bit         stall;
    logic [7:0] hd;
    logic [2:0] hi;
    logic       hl;
    exp_t       e;
    stall = 1'b0;
    hd = '0; hi = '0; hl = 1'b0;
    forever begin
      @(negedge clk);
      if (stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hd);
        check("hold_idx", out_idx, hi);
        check("hold_last", out_last, hl);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.d);
          check("out_idx", out_idx, e.idx);
          check("out_last", out_last, e.last);
        end
        acc_total++;
        if (out_last) last_cyc = cyc;
      end
      if (credit_chk && busy) check("credit", (int'(read_addr) <= (acc_total - acc_base + 2)), 1);
      stall = out_valid && !out_ready;
      hd = out_data;
      hi = out_idx;
      hl = out_last;
    end
  end

  initial begin
    int k;
    rst = 1'b1;
    norm_valid = 1'b0;
    for (int i = 0; i < RW; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;

    // Unit probability at element 3, latency and full-row timing.
    mem[3] = 33'h1_0000_0000;
    fire();
    check("addr0_at_n1", read_addr, 0);
    check("busy_at_n1", busy, 1);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("first_latency", cyc - n0, 3);
    wait_idle();
    check("last_xfer_cycle", last_cyc - n0, 10);
    check("row_count_unit", acc_total - acc_base, 8);

    // Quantization corner values.
    mem[0] = 33'h0_0080_0000;
    mem[1] = 33'h0_FFFF_FFFF;
    mem[2] = 33'h0_0100_0000;
    mem[3] = 33'h0_017F_FFFF;
    mem[4] = 33'h0_0180_0000;
    mem[5] = 33'h1_0000_0000;
    mem[6] = 33'h0_5A7F_FFFF;
    mem[7] = 33'h0_FF80_0000;
    fire();
    wait_idle();
    check("row_count_round", acc_total - acc_base, 8);

    // Backpressure 1,0,0,1 then two random-ready rows.
    ready_mode = 1;
    credit_chk = 1'b1;
    for (int i = 0; i < RW; i++) mem[i] = {1'b0, 32'($urandom)};
    fire();
    wait_idle();
    check("row_count_bp", acc_total - acc_base, 8);
    ready_mode = 2;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < RW; i++) mem[i] = {1'($urandom_range(0, 1)), 32'($urandom)};
      fire();
      wait_idle();
      check("row_count_rand", acc_total - acc_base, 8);
    end
    credit_chk = 1'b0;
    ready_mode = 0;

    // Overrun: second pulse two cycles after the first.
    fire();
    @(posedge clk); #1;
    norm_valid = 1'b1;
    @(posedge clk); #1;
    norm_valid = 1'b0;
    check("err_set", err_overrun, 1);
    wait_idle();
    check("row_count_ovr", acc_total - acc_base, 8);
    check("err_sticky", err_overrun, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("err_cleared", err_overrun, 0);

    // Reset mid-row after four transfers.
    for (int i = 0; i < RW; i++) mem[i] = {1'b0, 32'($urandom)};
    fire();
    k = 0;
    while ((acc_total - acc_base) < 4 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("mid_row_reached", ((acc_total - acc_base) >= 4), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    chk_reset_vals();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("quiet_after_rst", out_valid, 0);
    end
    fire();
    wait_idle();
    check("row_count_after_rst", acc_total - acc_base, 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
